// File: rtl/lif_scheduler.sv
// lif_scheduler: one LIF update engine time-multiplexed over NUM_NEURONS chained neurons.
// Optional macro LIF_REFRACTORY_EN adds a 2-timestep refractory counter per neuron.
module lif_scheduler #(
  parameter int NUM_NEURONS = 4,
  parameter int IDX_W = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   ena,
  input  logic                   step,
  input  logic [7:0]             current,
  input  logic                   cfg_we,
  input  logic [1:0]             cfg_addr,
  input  logic [7:0]             cfg_data,
  input  logic [IDX_W-1:0]       sel,
  output logic                   busy,
  output logic                   done,
  output logic [NUM_NEURONS-1:0] spikes,
  output logic [7:0]             state_out
);
  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_UPDATE, S_DONE} state_t;
  state_t r_st, w_nx;
  logic [IDX_W-1:0] r_idx;
  logic [7:0] r_state [NUM_NEURONS];
  logic [7:0] r_thr, r_wt, r_op_s, r_op_in;
  logic [2:0] r_beta;
  logic [NUM_NEURONS-1:0] r_acc, r_spikes;
  logic r_busy, r_done;
  logic w_last, w_fire, w_hold, w_spk, w_clr;
  logic [7:0] w_decay, w_sat, w_new;
  logic [8:0] w_sum;
  assign w_last = r_idx == IDX_W'(NUM_NEURONS - 1);
  assign w_clr = r_st == S_IDLE && cfg_we && cfg_addr == 2'd3;
  assign w_decay = r_op_s - (r_op_s >> r_beta);
  assign w_sum = {1'b0, w_decay} + {1'b0, r_op_in};
  assign w_sat = w_sum[8] ? 8'hFF : w_sum[7:0];
  assign w_fire = w_sat >= r_thr;
  assign w_spk = !w_hold && w_fire;
  assign w_new = (w_hold || w_fire) ? 8'd0 : w_sat;
  assign busy = r_busy;
  assign done = r_done;
  assign spikes = r_spikes;
  assign state_out = (32'(sel) < NUM_NEURONS) ? r_state[sel] : 8'd0;
  always_comb begin
    w_nx = r_st;
    w_nx = (r_st == S_IDLE) ? (step ? S_LOAD : S_IDLE) :
           (r_st == S_LOAD) ? S_UPDATE :
           (r_st == S_UPDATE) ? (w_last ? S_DONE : S_LOAD) : S_IDLE;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_st <= S_IDLE;
    else if (ena) r_st <= w_nx;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx <= '0;
      r_thr <= 8'd200;
      r_beta <= 3'd3;
      r_wt <= 8'd64;
      r_op_s <= '0;
      r_op_in <= '0;
      r_acc <= '0;
      r_spikes <= '0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
      for (int i = 0; i < NUM_NEURONS; i++) r_state[i] <= '0;
    end else if (ena) begin
      r_done <= 1'b0;
      if (r_st == S_IDLE) begin
        if (cfg_we && cfg_addr == 2'd0) r_thr <= cfg_data;
        if (cfg_we && cfg_addr == 2'd1) r_beta <= cfg_data[2:0];
        if (cfg_we && cfg_addr == 2'd2) r_wt <= cfg_data;
        if (w_clr) for (int i = 0; i < NUM_NEURONS; i++) r_state[i] <= '0;
        if (step) begin
          r_idx <= '0;
          r_busy <= 1'b1;
        end
      end
      if (r_st == S_LOAD) begin
        r_op_s <= r_state[r_idx];
        r_op_in <= (r_idx == '0) ? current : (r_spikes[r_idx - IDX_W'(1)] ? r_wt : 8'd0);
      end
      if (r_st == S_UPDATE) begin
        r_state[r_idx] <= w_new;
        r_acc[r_idx] <= w_spk;
        if (!w_last) r_idx <= r_idx + IDX_W'(1);
      end
      if (r_st == S_DONE) begin
        r_spikes <= r_acc;
        r_done <= 1'b1;
        r_busy <= 1'b0;
      end
    end
  end
`ifdef LIF_REFRACTORY_EN
  logic [1:0] r_ref [NUM_NEURONS];
  assign w_hold = r_ref[r_idx] != 2'd0;
  // A spike arms the counter; held updates count it back down to zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) for (int i = 0; i < NUM_NEURONS; i++) r_ref[i] <= '0;
    else if (ena) begin
      if (w_clr) for (int i = 0; i < NUM_NEURONS; i++) r_ref[i] <= '0;
      if (r_st == S_UPDATE) r_ref[r_idx] <= w_hold ? r_ref[r_idx] - 2'd1 : (w_fire ? 2'd2 : 2'd0);
    end
  end
`else
  assign w_hold = 1'b0;
`endif
endmodule
